// File: rtl/mesi_bus_pkg.sv
// Shared definitions for the MESI snooping-bus simulator.
//   - Bus command encodings (one-hot on the broadcast bus; zero means idle).
//   - Request op encodings as driven by the L1 controllers.
//   - Bus controller FSM state codes.
//   - MESI line-state codes used by the L1s.
//   - op_to_cmd(): maps a 2-bit request op to its bus command.
package mesi_bus_pkg;

    localparam logic [2:0] CMD_IDLE    = 3'b000;
    localparam logic [2:0] CMD_BUSRD   = 3'b100;
    localparam logic [2:0] CMD_BUSRDX  = 3'b010;
    localparam logic [2:0] CMD_BUSUPGR = 3'b001;

    localparam logic [1:0] OP_BUSRD    = 2'b00;
    localparam logic [1:0] OP_BUSRDX   = 2'b01;
    localparam logic [1:0] OP_BUSUPGR  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL  = 2'b11;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ARB    = 3'd1;
    localparam state_t ST_START  = 3'd2;
    localparam state_t ST_SNOOP  = 3'd3;
    localparam state_t ST_UPDATE = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        MESI_I = 3'b000,
        MESI_E = 3'b001,
        MESI_S = 3'b010,
        MESI_M = 3'b011
    } mesi_state_t;

    function automatic logic [2:0] op_to_cmd(input logic [1:0] op);
        case (op)
            OP_BUSRD:   return CMD_BUSRD;
            OP_BUSRDX:  return CMD_BUSRDX;
            OP_BUSUPGR: return CMD_BUSUPGR;
            default:    return CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter, purely combinational.
//   req    : request vector
//   ptr    : highest-priority index; search wraps 3 -> 0
//   gnt    : one-hot winner (zero when nothing requests)
//   gnt_id : binary index of the winner
//   any    : at least one request present
module rr_arbiter_4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       any
);

    logic [1:0] idx;

    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves it unassigned (no latch).
        idx    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // 2-bit addition wraps naturally from 3 back to 0.
            idx = ptr + 2'(i);
            if (!any && req[idx]) begin
                any    = 1'b1;
                gnt_id = idx;
            end
        end
        gnt = any ? (4'b0001 << gnt_id) : 4'b0000;
    end

endmodule

// File: rtl/snoop_bus_controller.sv
// Central snooping-bus master for the 4-core MESI cache simulator.
// Arbitrates L1 requests round-robin, broadcasts the winning transaction,
// collects snoop results into other_copy, waits for every core's MESI update
// and retires the transaction, counting retired transactions per command.
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/req_op  : per-core request and 2-bit op (core n at [2n+1:2n])
//   snoop_done        : per-core lookup finished
//   copy_core         : per-core valid-copy flag, sampled with snoop_done
//   updated           : per-core MESI/LRU update finished
//   bus_signals       : {requester_id, one-hot cmd}
//   find_start        : one-cycle lookup start broadcast
//   other_copy        : some core other than the requester holds the line
//   grant             : one-hot owner of the bus
//   txn_done          : one-cycle retire pulse to the requester
//   busrd/busrdx/busupgr_count : retired transactions per command
//   timeout_err, op_err        : sticky error flags
module snoop_bus_controller
    import mesi_bus_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int CNT_WIDTH = 20,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CORES-1:0]   req_valid,
    input  logic [2*NUM_CORES-1:0] req_op,
    input  logic [NUM_CORES-1:0]   snoop_done,
    input  logic [NUM_CORES-1:0]   copy_core,
    input  logic [NUM_CORES-1:0]   updated,
    output logic [4:0]             bus_signals,
    output logic                   find_start,
    output logic                   other_copy,
    output logic [NUM_CORES-1:0]   grant,
    output logic [NUM_CORES-1:0]   txn_done,
    output logic [CNT_WIDTH-1:0]   busrd_count,
    output logic [CNT_WIDTH-1:0]   busrdx_count,
    output logic [CNT_WIDTH-1:0]   busupgr_count,
    output logic                   timeout_err,
    output logic                   op_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // Last cycle allowed in SNOOP/UPDATE; the abort takes effect on that edge.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [1:0]    rr_ptr;
    logic [TW-1:0] timer;

    logic [3:0]    arb_gnt;
    logic [1:0]    arb_id;
    logic          arb_any;
    logic [1:0]    arb_op;
    logic          step_done;

    rr_arbiter_4 u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    assign arb_op = req_op[{arb_id, 1'b0} +: 2];

    // The wait condition for whichever of SNOOP/UPDATE we are in.
    assign step_done = (state == ST_SNOOP) ? (&snoop_done) : (&updated);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            timer         <= '0;
            bus_signals   <= '0;
            find_start    <= 1'b0;
            other_copy    <= 1'b0;
            grant         <= '0;
            txn_done      <= '0;
            busrd_count   <= '0;
            busrdx_count  <= '0;
            busupgr_count <= '0;
            timeout_err   <= 1'b0;
            op_err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every state update sees pre-edge values.
            find_start <= 1'b0;
            txn_done   <= '0;

            case (state)
                ST_IDLE: begin
                    if (|req_valid) state <= ST_ARB;
                end

                ST_ARB: begin
                    if (!arb_any) begin
                        // Requester withdrew before arbitration: nothing to serve.
                        state <= ST_IDLE;
                    end else if (arb_op == OP_ILLEGAL) begin
                        op_err   <= 1'b1;
                        txn_done <= arb_gnt;
                        rr_ptr   <= arb_id + 2'd1;
                        state    <= ST_IDLE;
                    end else begin
                        grant       <= arb_gnt;
                        bus_signals <= {arb_id, op_to_cmd(arb_op)};
                        find_start  <= 1'b1;
                        timer       <= '0;
                        state       <= ST_START;
                    end
                end

                ST_START: begin
                    state <= ST_SNOOP;
                end

                ST_SNOOP, ST_UPDATE: begin
                    if (step_done) begin
                        timer <= '0;
                        if (state == ST_SNOOP) begin
                            other_copy <= |(copy_core & ~grant);
                            state      <= ST_UPDATE;
                        end else begin
                            txn_done <= grant;
                            state    <= ST_DONE;
                        end
                    end else if (timer == TIMER_LAST) begin
                        // Abort: no retire pulse, no count, rr_ptr untouched.
                        timeout_err <= 1'b1;
                        grant       <= '0;
                        bus_signals <= '0;
                        other_copy  <= 1'b0;
                        timer       <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_DONE: begin
                    case (bus_signals[2:0])
                        CMD_BUSRD:   busrd_count   <= busrd_count + 1'b1;
                        CMD_BUSRDX:  busrdx_count  <= busrdx_count + 1'b1;
                        CMD_BUSUPGR: busupgr_count <= busupgr_count + 1'b1;
                        default:     ;
                    endcase
                    rr_ptr      <= bus_signals[4:3] + 2'd1;
                    grant       <= '0;
                    bus_signals <= '0;
                    other_copy  <= 1'b0;
                    state       <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed bench for snoop_bus_controller: a vector table of complete
// transactions plus hand-written timeout, illegal-op and mid-transaction
// reset sequences.
module tb_snoop_bus_controller;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [3:0]  snoop_done;
    logic [3:0]  copy_core;
    logic [3:0]  updated;
    logic [4:0]  bus_signals;
    logic        find_start;
    logic        other_copy;
    logic [3:0]  grant;
    logic [3:0]  txn_done;
    logic [19:0] busrd_count;
    logic [19:0] busrdx_count;
    logic [19:0] busupgr_count;
    logic        timeout_err;
    logic        op_err;

    int total = 0;
    int bad   = 0;

    snoop_bus_controller #(.NUM_CORES(4), .CNT_WIDTH(20), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .snoop_done    (snoop_done),
        .copy_core     (copy_core),
        .updated       (updated),
        .bus_signals   (bus_signals),
        .find_start    (find_start),
        .other_copy    (other_copy),
        .grant         (grant),
        .txn_done      (txn_done),
        .busrd_count   (busrd_count),
        .busrdx_count  (busrdx_count),
        .busupgr_count (busupgr_count),
        .timeout_err   (timeout_err),
        .op_err        (op_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] add_req;
        logic [7:0] op;
        logic [3:0] copy;
        logic [3:0] exp_grant;
        logic [4:0] exp_bus;
        logic       exp_oc;
        int         exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one transaction from the current negedge with snoop_done/updated
    // supplied by the caller. Reports what was broadcast and when it retired.
    task automatic run_txn(output logic [3:0] g, output logic [4:0] b, output logic oc,
                           output logic [3:0] td, output int lat, output int fs);
        logic oc_prev;
        g = '0; b = '0; oc = 1'b0; td = '0; lat = -1; fs = 0; oc_prev = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (find_start) begin
                fs++;
                g = grant;
                b = bus_signals;
            end
            if (txn_done != 4'b0000) begin
                td        = txn_done;
                oc        = oc_prev;
                lat       = i;
                req_valid = req_valid & ~txn_done;
                break;
            end
            oc_prev = other_copy;
        end
    endtask

    initial begin
        logic [3:0] g;
        logic [4:0] b;
        logic       oc;
        logic [3:0] td;
        int         lat;
        int         fs;
        int         tmo_at;
        int         td_at;
        int         fs_at;
        logic       seen_td;
        logic       bus_bad;

        reset = 1'b1; req_valid = '0; req_op = '0;
        snoop_done = 4'hF; copy_core = '0; updated = 4'hF;

        //             add_req  op     copy     grant    bus        oc    lat
        vecs[0] = '{4'b0100, 8'h00, 4'b0001, 4'b0100, 5'b10100, 1'b1, 5};
        vecs[1] = '{4'b1000, 8'h40, 4'b1000, 4'b1000, 5'b11010, 1'b0, 6};
        vecs[2] = '{4'b1011, 8'h00, 4'b0000, 4'b0001, 5'b00100, 1'b0, 6};
        vecs[3] = '{4'b0000, 8'h00, 4'b0000, 4'b0010, 5'b01100, 1'b0, 6};
        vecs[4] = '{4'b0000, 8'h00, 4'b0000, 4'b1000, 5'b11100, 1'b0, 6};
        vecs[5] = '{4'b1111, 8'h09, 4'b1111, 4'b0001, 5'b00010, 1'b1, 6};
        vecs[6] = '{4'b0000, 8'h09, 4'b1111, 4'b0010, 5'b01001, 1'b1, 6};
        vecs[7] = '{4'b0000, 8'h09, 4'b1111, 4'b0100, 5'b10100, 1'b1, 6};
        vecs[8] = '{4'b0000, 8'h09, 4'b1111, 4'b1000, 5'b11100, 1'b1, 6};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_outs", 32'({bus_signals, find_start, other_copy, grant, txn_done, timeout_err, op_err}), 32'd0);
        check("rst_rd_cnt", 32'(busrd_count), 32'd0);
        check("rst_rdx_upg_cnt", 32'({busrdx_count, busupgr_count} != 0), 32'd0);

        // Table of complete transactions with snoop_done/updated held high.
        for (int v = 0; v < 9; v++) begin
            req_op    = vecs[v].op;
            copy_core = vecs[v].copy;
            req_valid = req_valid | vecs[v].add_req;
            run_txn(g, b, oc, td, lat, fs);
            check($sformatf("v%0d_grant", v), 32'(g), 32'(vecs[v].exp_grant));
            check($sformatf("v%0d_bus", v), 32'(b), 32'(vecs[v].exp_bus));
            check($sformatf("v%0d_find_start_cnt", v), 32'(fs), 32'd1);
            check($sformatf("v%0d_other_copy", v), 32'(oc), 32'(vecs[v].exp_oc));
            check($sformatf("v%0d_txn_done", v), 32'(td), 32'(vecs[v].exp_grant));
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            if (v == 1) check("busrd_after_core2", 32'(busrd_count), 32'd1);
        end
        @(negedge clk);
        check("busrd_count", 32'(busrd_count), 32'd6);
        check("busrdx_count", 32'(busrdx_count), 32'd2);
        check("busupgr_count", 32'(busupgr_count), 32'd1);

        // Core 1 BusUpgr with core 3 never finishing its lookup.
        snoop_done = 4'b0111; req_op = 8'h08; copy_core = '0; req_valid = 4'b0010;
        tmo_at = -1; seen_td = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (txn_done != 4'b0000) seen_td = 1'b1;
            if (i == 3) check("tmo_bus_in_snoop", 32'(bus_signals), 32'(5'b01001));
            if (timeout_err) begin
                tmo_at = i;
                req_valid = '0;
                check("tmo_bus_cleared", 32'(bus_signals), 32'd0);
                check("tmo_grant_cleared", 32'(grant), 32'd0);
                break;
            end
        end
        check("tmo_cycle", 32'(tmo_at), 32'(3 + TO));
        check("tmo_no_txn_done", 32'(seen_td), 32'd0);
        check("tmo_counts_unchanged", 32'({busrd_count[3:0], busrdx_count[3:0], busupgr_count[3:0]}), 32'h621);
        snoop_done = 4'hF;
        @(negedge clk);

        // Core 0 illegal op.
        req_op = 8'h03; req_valid = 4'b0001;
        td_at = -1; bus_bad = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus_signals != 5'd0 || find_start) bus_bad = 1'b1;
            if (txn_done == 4'b0001 && td_at < 0) begin
                td_at = i;
                req_valid = '0;
            end
        end
        check("illegal_txn_done_cycle", 32'(td_at), 32'd2);
        check("illegal_op_err", 32'(op_err), 32'd1);
        check("illegal_bus_quiet", 32'(bus_bad), 32'd0);

        // Reset while core 2's transaction sits in UPDATE (rr_ptr is 1 here).
        req_op = 8'h00; copy_core = 4'b0001; updated = 4'b0000; req_valid = 4'b0100;
        fs_at = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (find_start) fs_at = i;
            if (fs_at > 0 && i == fs_at + 2) break;
        end
        check("upd_reached", 32'(fs_at > 0), 32'd1);
        check("upd_other_copy", 32'(other_copy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_outs", 32'({bus_signals, find_start, other_copy, grant, txn_done, timeout_err, op_err}), 32'd0);
        check("midrst_counts", 32'({busrd_count, busrdx_count, busupgr_count} != 0), 32'd0);
        reset = 1'b0; updated = 4'hF; copy_core = '0; req_valid = 4'b1111;
        run_txn(g, b, oc, td, lat, fs);
        check("postrst_grant_rr0", 32'(g), 32'b0001);
        check("postrst_latency", 32'(lat), 32'd5);
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
